vga_scan_counter: RTL and testbench

//   Raster timing generator for the VGA display path. Advances a pixel column/row scan

---
 rtl/vga_scan_counter_if.sv | 22 ++
 rtl/vga_scan_counter.sv | 90 +++++++++
 tb/tb_vga_scan_counter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_counter_if.sv
// Scan-position bus between the raster timing generator and its pixel-path consumers.
// The generator takes pix_ce in and drives the scan position and timing flags out.
interface vga_scan_counter_if;
  logic        pix_ce;
  logic [15:0] col;
  logic [15:0] row;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        line_start;
  logic        frame_start;

  modport master (
    input  pix_ce,
    output col, row, hsync, vsync, active, line_start, frame_start
  );

  modport slave (
    output pix_ce,
    input  col, row, hsync, vsync, active, line_start, frame_start
  );
endinterface

// File: rtl/vga_scan_counter.sv
// Raster timing generator: column/row scan counters plus registered sync, active-video
// and line/frame start flags, all decoded from the next scan position on the same edge.
module vga_scan_counter #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_scan_counter_if.master   bus
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned RW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
  localparam int unsigned HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
  localparam int unsigned VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

  logic [CW-1:0] col_q, col_n;
  logic [RW-1:0] row_q, row_n;
  logic          hsync_q, hsync_n;
  logic          vsync_q, vsync_n;
  logic          active_q, active_n;
  logic          line_start_q, line_start_n;
  logic          frame_start_q, frame_start_n;

  // Next scan position and its decoded flags; everything holds while pix_ce is low.
  always_comb begin
    col_n         = col_q;
    row_n         = row_q;
    hsync_n       = hsync_q;
    vsync_n       = vsync_q;
    active_n      = active_q;
    line_start_n  = 1'b0;
    frame_start_n = 1'b0;

    if (bus.pix_ce) begin
      if (col_q == CW'(H_TOTAL - 1)) begin
        col_n = '0;
        row_n = (row_q == RW'(V_TOTAL - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_n = col_q + CW'(1);
      end

      hsync_n       = !((col_n >= CW'(HS_FIRST)) && (col_n <= CW'(HS_LAST)));
      vsync_n       = !((row_n >= RW'(VS_FIRST)) && (row_n <= RW'(VS_LAST)));
      active_n      = (col_n < CW'(H_ACTIVE)) && (row_n < RW'(V_ACTIVE));
      line_start_n  = (col_n == '0);
      frame_start_n = (col_n == '0) && (row_n == '0);
    end
  end

  // Reset parks the scan on the last pixel so the first pix_ce lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q         <= CW'(H_TOTAL - 1);
      row_q         <= RW'(V_TOTAL - 1);
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      col_q         <= col_n;
      row_q         <= row_n;
      hsync_q       <= hsync_n;
      vsync_q       <= vsync_n;
      active_q      <= active_n;
      line_start_q  <= line_start_n;
      frame_start_q <= frame_start_n;
    end
  end

  assign bus.col         = 16'(col_q);
  assign bus.row         = 16'(row_q);
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.active      = active_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_counter.sv
// Bench for vga_scan_counter: a full-size 640x480 instance and a tiny-timing instance
// share one stimulus; both are checked every cycle against a pixel-index model.
module tb_vga_scan_counter;

  // Instance 0: standard VGA timing. Instance 1: 16x11 raster for frame-level tests.
  localparam int HA [2] = '{640, 8};
  localparam int HF [2] = '{16,  2};
  localparam int HS [2] = '{96,  3};
  localparam int HB [2] = '{48,  3};
  localparam int VA [2] = '{480, 5};
  localparam int VF [2] = '{10,  2};
  localparam int VS [2] = '{2,   2};
  localparam int VB [2] = '{33,  2};

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic pix_ce = 1'b0;
  bit   run_chk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vga_scan_counter_if bus_big ();
  vga_scan_counter_if bus_sml ();
  assign bus_big.pix_ce = pix_ce;
  assign bus_sml.pix_ce = pix_ce;

  vga_scan_counter u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_big)
  );

  vga_scan_counter #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (5), .V_FP (2), .V_SYNC (2), .V_BP (2)
  ) u_sml (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_sml)
  );

  always #5 clk = ~clk;

  function automatic int htot(input int k);
    return HA[k] + HF[k] + HS[k] + HB[k];
  endfunction

  function automatic int vtot(input int k);
    return VA[k] + VF[k] + VS[k] + VB[k];
  endfunction

  // Model: linear pixel index within the frame, plus whether the last edge had pix_ce.
  int p   [2];
  bit ceq [2];
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        p[k]   <= htot(k) * vtot(k) - 1;
        ceq[k] <= 1'b0;
      end else begin
        if (pix_ce) p[k] <= (p[k] + 1) % (htot(k) * vtot(k));
        ceq[k] <= pix_ce;
      end
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d at %0t: got %0d, expected %0d", name, k, $time, act, exp);
    end
  endtask

  task automatic check_model(input int k, input logic [15:0] col, input logic [15:0] row,
                             input logic hs, input logic vs, input logic act,
                             input logic ls, input logic fs);
    int c, r;
    c = p[k] % htot(k);
    r = p[k] / htot(k);
    check("col", k, 32'(col), c);
    check("row", k, 32'(row), r);
    check("hsync", k, 32'(hs), 32'(!(c >= HA[k] + HF[k] && c < HA[k] + HF[k] + HS[k])));
    check("vsync", k, 32'(vs), 32'(!(r >= VA[k] + VF[k] && r < VA[k] + VF[k] + VS[k])));
    check("active", k, 32'(act), 32'(c < HA[k] && r < VA[k]));
    check("line_start", k, 32'(ls), 32'(ceq[k] && c == 0));
    check("frame_start", k, 32'(fs), 32'(ceq[k] && p[k] == 0));
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      check_model(0, bus_big.col, bus_big.row, bus_big.hsync, bus_big.vsync,
                  bus_big.active, bus_big.line_start, bus_big.frame_start);
      check_model(1, bus_sml.col, bus_sml.row, bus_sml.hsync, bus_sml.vsync,
                  bus_sml.active, bus_sml.line_start, bus_sml.frame_start);
    end
  end

  task automatic tick(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ls_cnt, hs_lo, act_lo, hs_first, hs_last, vs_lo, n;
    bit found;

    repeat (2) tick(1'b0);
    run_chk = 1'b1;

    // Reset values
    check("rst_col", 0, 32'(bus_big.col), 799);
    check("rst_row", 0, 32'(bus_big.row), 524);
    check("rst_hsync", 0, 32'(bus_big.hsync), 1);
    check("rst_vsync", 0, 32'(bus_big.vsync), 1);
    check("rst_active", 0, 32'(bus_big.active), 0);
    check("rst_fs", 0, 32'(bus_big.frame_start), 0);
    check("rst_col", 1, 32'(bus_sml.col), 15);
    check("rst_row", 1, 32'(bus_sml.row), 10);

    rst_n = 1'b1;
    repeat (2) tick(1'b0);
    check("hold_col", 0, 32'(bus_big.col), 799);

    // First pix_ce lands on (0,0) with both strobes for one clock
    tick(1'b1);
    check("t1_col", 0, 32'(bus_big.col), 0);
    check("t1_row", 0, 32'(bus_big.row), 0);
    check("t1_active", 0, 32'(bus_big.active), 1);
    check("t1_ls", 0, 32'(bus_big.line_start), 1);
    check("t1_fs", 0, 32'(bus_big.frame_start), 1);
    tick(1'b0);
    check("t1_ls_off", 0, 32'(bus_big.line_start), 0);
    check("t1_fs_off", 0, 32'(bus_big.frame_start), 0);
    check("t1_col_hold", 0, 32'(bus_big.col), 0);

    // 800 pulses at one-in-four rate: one full line sweep plus wrap
    ls_cnt = 0; hs_lo = 0; act_lo = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 800; i++) begin
      tick(1'b1);
      if (bus_big.line_start) ls_cnt++;
      if (!bus_big.hsync) begin
        hs_lo++;
        if (hs_first < 0) hs_first = int'(bus_big.col);
        hs_last = int'(bus_big.col);
      end
      if (!bus_big.active) act_lo++;
      repeat (3) tick(1'b0);
    end
    check("t2_ls_count", 0, 32'(ls_cnt), 1);
    check("t2_col_wrap", 0, 32'(bus_big.col), 0);
    check("t2_row", 0, 32'(bus_big.row), 1);
    check("t3_hs_width", 0, 32'(hs_lo), 96);
    check("t3_hs_first", 0, 32'(hs_first), 656);
    check("t3_hs_last", 0, 32'(hs_last), 751);
    check("t3_active_lo", 0, 32'(act_lo), 160);

    // Continuous pix_ce: frame period and vertical timing on the small raster
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick(1'b1);
      found = bus_sml.frame_start;
    end
    check("t4_fs_seen", 1, 32'(found), 1);
    n = 0; vs_lo = 0; act_lo = 0; found = 1'b0;
    while (n < 400 && !found) begin
      tick(1'b1);
      n++;
      if (!bus_sml.vsync) vs_lo++;
      if (!bus_sml.active) act_lo++;
      found = bus_sml.frame_start;
    end
    check("t4_frame_period", 1, 32'(n), 176);
    check("t4_vs_clks", 1, 32'(vs_lo), 32);
    check("t4_active_lo", 1, 32'(act_lo), 136);

    // Line period on the full-size raster
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick(1'b1);
      found = bus_big.line_start;
    end
    check("t4_ls_seen", 0, 32'(found), 1);
    n = 0; found = 1'b0;
    while (n < 2000 && !found) begin
      tick(1'b1);
      n++;
      found = bus_big.line_start;
    end
    check("t4_line_period", 0, 32'(n), 800);

    // Mid-frame reset while both syncs are low
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick(1'b1);
      found = (bus_sml.col == 16'd11) && (bus_sml.row == 16'd8);
    end
    check("t5_reached", 1, 32'(found), 1);
    check("t5_hs_low", 1, 32'(bus_sml.hsync), 0);
    check("t5_vs_low", 1, 32'(bus_sml.vsync), 0);
    rst_n = 1'b0;
    #1;
    check("t5_hsync", 1, 32'(bus_sml.hsync), 1);
    check("t5_vsync", 1, 32'(bus_sml.vsync), 1);
    check("t5_active", 1, 32'(bus_sml.active), 0);
    check("t5_col", 1, 32'(bus_sml.col), 15);
    check("t5_row", 1, 32'(bus_sml.row), 10);
    check("t5_col", 0, 32'(bus_big.col), 799);
    check("t5_row", 0, 32'(bus_big.row), 524);
    repeat (2) tick(1'b0);
    rst_n = 1'b1;
    tick(1'b0);

    // Boundary wrap from the last pixel of the frame
    repeat (176) tick(1'b1);
    check("t6_pre_col", 1, 32'(bus_sml.col), 15);
    check("t6_pre_row", 1, 32'(bus_sml.row), 10);
    tick(1'b1);
    check("t6_col", 1, 32'(bus_sml.col), 0);
    check("t6_row", 1, 32'(bus_sml.row), 0);
    check("t6_fs", 1, 32'(bus_sml.frame_start), 1);
    check("t6_ls", 1, 32'(bus_sml.line_start), 1);
    check("t6_hsync", 1, 32'(bus_sml.hsync), 1);
    check("t6_vsync", 1, 32'(bus_sml.vsync), 1);
    tick(1'b0);
    tick(1'b0);

    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
